// File: rtl/rram_op_sequencer.sv
// Single-row operation sequencer for the 16x16 RRAM compute macro (CSA/ADC reads, SET/RESET/FORM).
// Define RRAM_VERIFY_EN to add read-after-write verify with re-pulse after SET/RESET.
module rram_op_sequencer #(
    parameter int T_PRE     = 2,
    parameter int T_SENSE   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_row,
    input  logic [15:0] cmd_cols,
    input  logic [7:0]  cmd_pulse,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] in1_wl,
    output logic [15:0] in0_wl,
    output logic [15:0] in1_bl,
    output logic [15:0] in0_bl,
    output logic [15:0] in1_sl,
    output logic [15:0] in0_sl,
    output logic        en_wl,
    output logic        en_bl,
    output logic        en_sl,
    output logic        pre,
    output logic        en_csa,
    output logic        saen_csa,
    output logic [1:0]  clk_en_adc,
    input  logic [15:0] csa_in,
    input  logic [15:0] adc0_in,
    input  logic [15:0] adc1_in,
    input  logic [15:0] adc2_in
);
    // state   | meaning
    // IDLE    | ready for a command, macro idle
    // SETUP   | bias codes applied, drivers off
    // PRE     | bit-line precharge with drivers on
    // SENSE   | bias settle, CSA enabled or ADC sampling
    // LATCH   | CSA strobe / ADC convert, result captured at exit
    // PULSE   | write pulse with drivers on
    // RECOVER | drivers off, codes held
    // RESP    | response presented, macro idle
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PRE, S_SENSE, S_LATCH, S_PULSE, S_RECOVER, S_RESP
    } state_t;

    localparam logic [2:0] OP_RD_CSA = 3'd0;
    localparam logic [2:0] OP_RD_ADC = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_RESET  = 3'd3;
    localparam logic [2:0] OP_FORM   = 3'd4;
    localparam logic [7:0] PRE_LOAD   = 8'(T_PRE - 1);
    localparam logic [7:0] SENSE_LOAD = 8'(T_SENSE - 1);

    if (T_PRE < 1 || T_PRE > 256 || T_SENSE < 1 || T_SENSE > 256 ||
        MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_param_check
        $error("rram_op_sequencer: timing/retry parameter out of range");
    end

    state_t      state, state_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic [2:0]  op_q;
    logic [3:0]  row_q;
    logic [15:0] cols_q;
    logic [7:0]  pulse_q;
    logic [31:0] data_q;
    logic        err_q;
    logic        alive_q;
    logic        verify_q;
    logic [3:0]  retry_q;
    logic        accept;
    logic        read_mode;
    logic        csa_mode;
    logic        drive;
    logic        en_lines;
    logic [15:0] csa_masked;
    logic [31:0] adc_data;
    logic        adc_bubble;
    logic [1:0]  wl_code, bl_code, sl_code;
    logic [15:0] row_sel;

    assign accept     = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign read_mode  = (op_q == OP_RD_CSA) || (op_q == OP_RD_ADC) || verify_q;
    assign csa_mode   = (op_q == OP_RD_CSA) || verify_q;
    assign csa_masked = csa_in & cols_q;

`ifdef RRAM_VERIFY_EN
    logic       verify_nxt;
    logic [3:0] retry_nxt;
    logic       verify_pass;
    logic       is_vwrite;

    assign is_vwrite   = (op_q == OP_SET) || (op_q == OP_RESET);
    assign verify_pass = (op_q == OP_SET) ? (data_q[15:0] == cols_q) : (data_q[15:0] == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_q <= 1'b0;
            retry_q  <= 4'd0;
        end else begin
            verify_q <= verify_nxt;
            retry_q  <= retry_nxt;
        end
    end
`else
    assign verify_q = 1'b0;
    assign retry_q  = 4'd0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
`ifdef RRAM_VERIFY_EN
        verify_nxt = verify_q;
        retry_nxt  = retry_q;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_op > OP_FORM) ? S_RESP : S_SETUP;
`ifdef RRAM_VERIFY_EN
                    verify_nxt = 1'b0;
                    retry_nxt  = 4'd0;
`endif
                end
            end
            S_SETUP: begin
                if (read_mode) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = PRE_LOAD;
                end else begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = (pulse_q == 8'd0) ? 8'd0 : pulse_q - 8'd1;
                end
            end
            S_PRE: begin
                if (cnt_q == 8'd0) begin
                    state_nxt = S_SENSE;
                    cnt_nxt   = SENSE_LOAD;
                end
            end
            S_SENSE: if (cnt_q == 8'd0) state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_RECOVER;
            S_PULSE: if (cnt_q == 8'd0) state_nxt = S_RECOVER;
            S_RECOVER: begin
`ifdef RRAM_VERIFY_EN
                if (is_vwrite && !verify_q) begin
                    state_nxt  = S_PRE;
                    cnt_nxt    = PRE_LOAD;
                    verify_nxt = 1'b1;
                end else if (verify_q && !verify_pass && retry_q != 4'(MAX_RETRY)) begin
                    // back through SETUP so the write bias settles before the re-pulse
                    state_nxt  = S_SETUP;
                    verify_nxt = 1'b0;
                    retry_nxt  = retry_q + 4'd1;
                end else begin
                    state_nxt = S_RESP;
                end
`else
                state_nxt = S_RESP;
`endif
            end
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 3'd0;
            row_q   <= 4'd0;
            cols_q  <= 16'd0;
            pulse_q <= 8'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt_q   <= cnt_nxt;
            alive_q <= 1'b1;
            if (accept) begin
                op_q    <= cmd_op;
                row_q   <= cmd_row;
                cols_q  <= cmd_cols;
                pulse_q <= cmd_pulse;
                data_q  <= 32'd0;
                err_q   <= (cmd_op > OP_FORM);
            end
            if (state == S_LATCH) begin
                if (csa_mode) begin
                    data_q <= {12'd0, retry_q, csa_masked};
                end else begin
                    data_q <= adc_data;
                    err_q  <= adc_bubble;
                end
            end
`ifdef RRAM_VERIFY_EN
            if (state == S_RECOVER && verify_q && state_nxt == S_RESP) err_q <= !verify_pass;
`endif
        end
    end

    // A healthy comparator column is thermometer coded; any gap is a bubble.
    always_comb begin
        adc_data   = 32'd0;
        adc_bubble = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (cols_q[c]) begin
                adc_data[2*c +: 2] = 2'(adc0_in[c]) + 2'(adc1_in[c]) + 2'(adc2_in[c]);
                if ((adc1_in[c] && !adc0_in[c]) || (adc2_in[c] && !adc1_in[c])) adc_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        drive      = 1'b0;
        en_lines   = 1'b0;
        pre        = 1'b0;
        en_csa     = 1'b0;
        saen_csa   = 1'b0;
        clk_en_adc = 2'b00;
        case (state)
            S_SETUP, S_RECOVER: drive = 1'b1;
            S_PULSE: begin
                drive    = 1'b1;
                en_lines = 1'b1;
            end
            S_PRE: begin
                drive    = 1'b1;
                en_lines = 1'b1;
                pre      = 1'b1;
            end
            S_SENSE: begin
                drive    = 1'b1;
                en_lines = 1'b1;
                if (csa_mode) en_csa = 1'b1;
                else          clk_en_adc = 2'b01;
            end
            S_LATCH: begin
                drive    = 1'b1;
                en_lines = 1'b1;
                if (csa_mode) begin
                    en_csa   = 1'b1;
                    saen_csa = 1'b1;
                end else begin
                    clk_en_adc = 2'b10;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wl_code = 2'b00;
        bl_code = 2'b00;
        sl_code = 2'b00;
        if (drive) begin
            if (read_mode) begin
                wl_code = 2'b01;
                bl_code = 2'b01;
            end else begin
                case (op_q)
                    OP_SET:   begin wl_code = 2'b11; bl_code = 2'b10; end
                    OP_RESET: begin wl_code = 2'b11; sl_code = 2'b10; end
                    OP_FORM:  begin wl_code = 2'b11; bl_code = 2'b11; end
                    default:  ;
                endcase
            end
        end
    end

    assign row_sel = 16'd1 << row_q;
    assign in1_wl  = row_sel & {16{wl_code[1]}};
    assign in0_wl  = row_sel & {16{wl_code[0]}};
    assign in1_bl  = cols_q  & {16{bl_code[1]}};
    assign in0_bl  = cols_q  & {16{bl_code[0]}};
    assign in1_sl  = cols_q  & {16{sl_code[1]}};
    assign in0_sl  = cols_q  & {16{sl_code[0]}};

    assign en_wl     = en_lines;
    assign en_bl     = en_lines;
    assign en_sl     = en_lines;
    assign cmd_ready = alive_q && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_rram_op_sequencer.sv
// Randomized self-checking bench for rram_op_sequencer against a cycle-count/result reference model.
`timescale 1ns/1ps
module tb_rram_op_sequencer;
    localparam int T_PRE     = 2;
    localparam int T_SENSE   = 2;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [3:0]  cmd_row = 4'd0;
    logic [15:0] cmd_cols = 16'd0;
    logic [7:0]  cmd_pulse = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] in1_wl, in0_wl, in1_bl, in0_bl, in1_sl, in0_sl;
    logic        en_wl, en_bl, en_sl, pre, en_csa, saen_csa;
    logic [1:0]  clk_en_adc;
    logic [15:0] csa_in = 16'd0, adc0_in = 16'd0, adc1_in = 16'd0, adc2_in = 16'd0;

    logic [15:0] csa_good, a0_good, a1_good, a2_good;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rram_op_sequencer #(.T_PRE(T_PRE), .T_SENSE(T_SENSE), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_row(cmd_row),
        .cmd_cols(cmd_cols), .cmd_pulse(cmd_pulse),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .in1_wl(in1_wl), .in0_wl(in0_wl), .in1_bl(in1_bl), .in0_bl(in0_bl),
        .in1_sl(in1_sl), .in0_sl(in0_sl),
        .en_wl(en_wl), .en_bl(en_bl), .en_sl(en_sl), .pre(pre), .en_csa(en_csa),
        .saen_csa(saen_csa), .clk_en_adc(clk_en_adc),
        .csa_in(csa_in), .adc0_in(adc0_in), .adc1_in(adc1_in), .adc2_in(adc2_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {WL in1,in0, BL in1,in0, SL in1,in0} per operation
    function automatic logic [5:0] bias_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 6'b01_01_00;
            3'd2:       return 6'b11_10_00;
            3'd3:       return 6'b11_00_10;
            3'd4:       return 6'b11_11_00;
            default:    return 6'b00_00_00;
        endcase
    endfunction

    function automatic logic [95:0] exp_lines(input logic [2:0] op, input logic [3:0] row,
                                              input logic [15:0] cols);
        logic [5:0]  b;
        logic [15:0] r;
        b = bias_of(op);
        r = 16'd1 << row;
        return {r & {16{b[5]}}, r & {16{b[4]}}, cols & {16{b[3]}},
                cols & {16{b[2]}}, cols & {16{b[1]}}, cols & {16{b[0]}}};
    endfunction

    function automatic logic macro_active();
        return |{en_wl, en_bl, en_sl, pre, en_csa, saen_csa, clk_en_adc,
                 in1_wl, in0_wl, in1_bl, in0_bl, in1_sl, in0_sl};
    endfunction

    task automatic rand_adc();
        logic [2:0] p;
        for (int c = 0; c < 16; c++) begin
            if ($urandom_range(0, 3) == 0) p = 3'($urandom_range(0, 7));
            else                           p = 3'((1 << $urandom_range(0, 3)) - 1);
            a0_good[c] = p[0];
            a1_good[c] = p[1];
            a2_good[c] = p[2];
        end
    endtask

    task automatic do_accept(input logic [2:0] op, input logic [3:0] row, input logic [15:0] cols,
                             input logic [7:0] pulse, output bit ok);
        int guard;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_cols  = cols;
        cmd_pulse = pulse;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 50) begin
            ok = cmd_ready;
            @(posedge clk);
            if (!ok) begin
                guard++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Called and returns on a negedge; leaves rsp_ready high so the next command overlaps RESP.
    task automatic run_txn(input logic [2:0] op, input logic [3:0] row, input logic [15:0] cols,
                           input logic [7:0] pulse, input int hold);
        int pp, e_lat, e_en, e_pre, e_saen, e_csa, e_smp, e_cnv;
        int cyc, en_c, pre_c, saen_c, csa_c, smp_c, cnv_c, n;
        logic [31:0] e_data, d0;
        logic        e_err, e0, verify_w, bad_lines, busy_rdy, hold_bad, done;
        logic [95:0] obs;
        bit ok;

        pp = (pulse == 8'd0) ? 1 : int'(pulse);
        e_data = 32'd0; e_err = 1'b0; verify_w = 1'b0;
        e_pre = 0; e_saen = 0; e_csa = 0; e_smp = 0; e_cnv = 0;
        if (op == 3'd0) begin
            e_data = {16'd0, csa_good & cols};
            e_lat = 1 + T_PRE + T_SENSE + 3; e_en = T_PRE + T_SENSE + 1;
            e_pre = T_PRE; e_saen = 1; e_csa = T_SENSE + 1;
        end else if (op == 3'd1) begin
            for (int c = 0; c < 16; c++) begin
                if (cols[c]) begin
                    n = int'(a0_good[c]) + int'(a1_good[c]) + int'(a2_good[c]);
                    e_data[2*c +: 2] = 2'(n);
                    if (int'({a2_good[c], a1_good[c], a0_good[c]}) != (1 << n) - 1) e_err = 1'b1;
                end
            end
            e_lat = 1 + T_PRE + T_SENSE + 3; e_en = T_PRE + T_SENSE + 1;
            e_pre = T_PRE; e_smp = T_SENSE; e_cnv = 1;
        end else if (op <= 3'd4) begin
            e_lat = pp + 3; e_en = pp;
`ifdef RRAM_VERIFY_EN
            if (op != 3'd4) begin
                logic [15:0] m;
                logic        pass;
                int          k, r;
                m = csa_good & cols;
                pass = (op == 3'd2) ? (m == cols) : (m == 16'd0);
                r = pass ? 0 : MAX_RETRY;
                k = 1 + r;
                e_data = {12'd0, 4'(r), m}; e_err = !pass; verify_w = 1'b1;
                e_lat = k * (pp + 4 + T_PRE + T_SENSE) + 1;
                e_en = k * (pp + T_PRE + T_SENSE + 1);
                e_pre = k * T_PRE; e_saen = k; e_csa = k * (T_SENSE + 1);
            end
`endif
        end else begin
            e_err = 1'b1; e_lat = 1; e_en = 0;
        end

        do_accept(op, row, cols, pulse, ok);
        if (!ok) return;

        cyc = 1; done = 1'b0; bad_lines = 1'b0; busy_rdy = 1'b0;
        en_c = 0; pre_c = 0; saen_c = 0; csa_c = 0; smp_c = 0; cnv_c = 0;
        while (!done && cyc < 3000) begin
            if (rsp_valid) done = 1'b1;
            else begin
                if (en_wl) en_c++;
                if (pre) pre_c++;
                if (saen_csa) saen_c++;
                if (en_csa) csa_c++;
                if (clk_en_adc == 2'b01) smp_c++;
                if (clk_en_adc == 2'b10) cnv_c++;
                if (clk_en_adc == 2'b11 || en_wl !== en_bl || en_wl !== en_sl) bad_lines = 1'b1;
                if (cmd_ready) busy_rdy = 1'b1;
                obs = {in1_wl, in0_wl, in1_bl, in0_bl, in1_sl, in0_sl};
                if (!(obs === exp_lines(op, row, cols) ||
                      (verify_w && obs === exp_lines(3'd0, row, cols)))) bad_lines = 1'b1;
                // only the latch cycle sees the real macro outputs
                if (saen_csa || clk_en_adc == 2'b10) begin
                    csa_in = csa_good; adc0_in = a0_good; adc1_in = a1_good; adc2_in = a2_good;
                end else begin
                    csa_in = 16'($urandom); adc0_in = 16'($urandom);
                    adc1_in = 16'($urandom); adc2_in = 16'($urandom);
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        check("rsp_data", rsp_data, e_data);
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("latency", 32'(cyc), 32'(e_lat));
        check("en_cycles", 32'(en_c), 32'(e_en));
        check("pre_cycles", 32'(pre_c), 32'(e_pre));
        check("saen_cycles", 32'(saen_c), 32'(e_saen));
        check("en_csa_cycles", 32'(csa_c), 32'(e_csa));
        check("adc_phases", {16'(smp_c), 16'(cnv_c)}, {16'(e_smp), 16'(e_cnv)});
        check("line_codes", 32'(bad_lines), 32'd0);
        check("ready_busy", 32'(busy_rdy), 32'd0);

        d0 = rsp_data; e0 = rsp_err; hold_bad = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || cmd_ready || macro_active())
                hold_bad = 1'b1;
        end
        check("resp_hold", 32'(hold_bad), 32'd0);
        rsp_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic act;
        csa_good = 16'd0; a0_good = 16'd0; a1_good = 16'd0; a2_good = 16'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(macro_active() | cmd_ready | rsp_valid | rsp_err), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        csa_good = 16'hA5A5;
        run_txn(3'd0, 4'd5, 16'h00FF, 8'd0, 0);

        a0_good = 16'($urandom); a1_good = 16'($urandom); a2_good = 16'($urandom);
        a0_good[1:0] = 2'b11; a1_good[1:0] = 2'b11; a2_good[1:0] = 2'b10;
        run_txn(3'd1, 4'd2, 16'h0003, 8'd0, 1);
        a1_good[0] = 1'b0; a2_good[0] = 1'b1;
        run_txn(3'd1, 4'd2, 16'h0003, 8'd0, 0);

        csa_good = 16'h0000;
        run_txn(3'd2, 4'd0, 16'h8001, 8'd4, 0);
        run_txn(3'd6, 4'd7, 16'hFFFF, 8'd3, 2);
        run_txn(3'd3, 4'd9, 16'h0F0F, 8'd0, 10);
        run_txn(3'd4, 4'd15, 16'h1234, 8'd2, 0);

        // reset pulsed mid-pulse: drivers drop at once and no response appears
        do_accept(3'd2, 4'd3, 16'hFFFF, 8'd20, ok);
        act = 1'b0;
        for (int i = 0; i < 6 && !act; i++) begin
            act = en_wl;
            @(negedge clk);
        end
        check("pulse_started", 32'(en_wl), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_drop", 32'(macro_active() | rsp_valid | cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) act = 1'b1;
        end
        check("no_rsp_after_reset", 32'(act), 32'd0);
        check("idle_after_reset", 32'(cmd_ready), 32'd1);

        for (int t = 0; t < 40; t++) begin
            csa_good = 16'($urandom);
            if ($urandom_range(0, 3) == 0) csa_good = 16'd0;
            rand_adc();
            run_txn(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom),
                    8'($urandom_range(0, 6)), $urandom_range(0, 4));
        end

        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("final_idle", 32'(cmd_ready), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
